// File: rtl/data_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_pkg
// Description : Shared constants and types for the data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package data_memory_pkg;

    // Memory geometry: 2**c_MEM_AW words of c_DATA_W bits.
    localparam int unsigned c_MEM_AW  = 8;
    localparam int unsigned c_DATA_W  = 32;

    // Transaction state encoding.
    localparam int unsigned            c_STATE_W = 1;
    localparam logic [c_STATE_W-1:0]   c_IDLE    = 1'b0;
    localparam logic [c_STATE_W-1:0]   c_ACCESS  = 1'b1;

    // Requester identity; also the index into per-requester response arrays.
    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_t;

endpackage
`default_nettype wire

// File: rtl/data_memory_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-way round-robin grant logic. Purely combinational; the
//               last-grant pointer register lives in the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2
    import data_memory_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output logic [1:0] gnt
);

    // A lone requester always wins; on a tie the one not granted last wins.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | (last == REQ_DBG));
        gnt[1] = req[1] & (~req[0] | (last == REQ_CPU));
    end

endmodule
`default_nettype wire

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_arbiter
// Description : Round-robin sharing of a single-port data memory between the
//               CPU load/store path and the debug/loader port. Each access is
//               a two-cycle grant/access transaction with a one-cycle
//               completion pulse back to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_arbiter
    import data_memory_pkg::*;
#(
    parameter int unsigned DATA_W = c_DATA_W,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned MEM_AW = c_MEM_AW
) (
    input  logic              clock,
    input  logic              reset_n,
    // requester 0: CPU load/store
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    // requester 1: debug/loader
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    // memory side
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_sg,
    input  logic [DATA_W-1:0] mem_read_data
);

    logic [c_STATE_W-1:0]   r_state;
    logic [c_STATE_W-1:0]   w_state_nxt;
    req_id_t                r_last;
    req_id_t                r_cmd_owner;
    logic                   r_cmd_we;
    logic [ADDR_W-1:0]      r_cmd_addr;
    logic [DATA_W-1:0]      r_cmd_wdata;

    logic [1:0]             w_arb_gnt;
    logic [1:0]             w_gnt;
    logic                   w_mem_write_sg;
    logic                   w_in_range;
    req_id_t                w_winner;

    logic [1:0]             r_rvalid;
    logic [1:0]             r_err;
    logic [1:0][DATA_W-1:0] r_rdata;

    rr_arbiter_2 u_rr_arbiter_2 (
        .req  ({m1_req, m0_req}),
        .last (r_last),
        .gnt  (w_arb_gnt)
    );

    // Anything above the memory index bits makes the address out of range.
    assign w_in_range = (r_cmd_addr[ADDR_W-1:MEM_AW] == '0);
    assign w_winner   = w_gnt[1] ? REQ_DBG : REQ_CPU;

    // State register; reset aborts any access in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the grant and write-strobe outputs of each state.
    always_comb begin
        w_state_nxt    = r_state;
        w_gnt          = 2'b00;
        w_mem_write_sg = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_gnt = w_arb_gnt;
                if (|w_arb_gnt) begin
                    w_state_nxt = c_ACCESS;
                end
            end
            c_ACCESS: begin
                w_mem_write_sg = r_cmd_we & w_in_range;
                w_state_nxt    = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Capture the winning command and advance the round-robin pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last      <= REQ_DBG;
            r_cmd_owner <= REQ_CPU;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
        end else if (|w_gnt) begin
            r_last      <= w_winner;
            r_cmd_owner <= w_winner;
            r_cmd_we    <= w_winner == REQ_DBG ? m1_we    : m0_we;
            r_cmd_addr  <= w_winner == REQ_DBG ? m1_addr  : m0_addr;
            r_cmd_wdata <= w_winner == REQ_DBG ? m1_wdata : m0_wdata;
        end
    end

    // Completion: pulse rvalid to the owner and hold rdata/err until its next one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalid <= '0;
            r_err    <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= '0;
            if (r_state == c_ACCESS) begin
                r_rvalid[r_cmd_owner] <= 1'b1;
                r_err[r_cmd_owner]    <= ~w_in_range;
                r_rdata[r_cmd_owner]  <= (w_in_range && !r_cmd_we) ? mem_read_data : '0;
            end
        end
    end

    // Memory address/data come straight from the command registers, so they
    // hold their last values between accesses.
    assign mem_address    = r_cmd_addr;
    assign mem_write_data = r_cmd_wdata;
    assign mem_write_sg   = w_mem_write_sg;

    assign m0_gnt    = w_gnt[0];
    assign m1_gnt    = w_gnt[1];
    assign m0_rvalid = r_rvalid[0];
    assign m1_rvalid = r_rvalid[1];
    assign m0_err    = r_err[0];
    assign m1_err    = r_err[1];
    assign m0_rdata  = r_rdata[0];
    assign m1_rdata  = r_rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_arbiter
// Description : Directed, table-driven bench for data_memory_arbiter with a
//               256-word memory behind it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_arbiter;

    logic        clock;
    logic        reset_n;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write_sg;

    logic [31:0] mem [256];

    int n_vec;
    int n_mis;

    typedef struct {
        logic        who;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [11];
    logic [31:0] last_rdata [2];

    data_memory_arbiter dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .m0_req         (m0_req),
        .m0_we          (m0_we),
        .m0_addr        (m0_addr),
        .m0_wdata       (m0_wdata),
        .m0_gnt         (m0_gnt),
        .m0_rvalid      (m0_rvalid),
        .m0_rdata       (m0_rdata),
        .m0_err         (m0_err),
        .m1_req         (m1_req),
        .m1_we          (m1_we),
        .m1_addr        (m1_addr),
        .m1_wdata       (m1_wdata),
        .m1_gnt         (m1_gnt),
        .m1_rvalid      (m1_rvalid),
        .m1_rdata       (m1_rdata),
        .m1_err         (m1_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write_sg   (mem_write_sg),
        .mem_read_data  (mem_read_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory: preloaded with a recognisable pattern, synchronous write.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | i;
    end
    always @(posedge clock) begin
        if (mem_write_sg) mem[mem_address[7:0]] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_address[7:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic who, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (who == 1'b0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic o;
        o = ~v.who;
        @(posedge clock); #1;
        set_req(v.who, 1'b1, v.we, v.addr, v.wdata);
        @(negedge clock);                                  // cycle 0: grant
        check($sformatf("v%0d_gnt", idx), v.who ? m1_gnt : m0_gnt, 1);
        check($sformatf("v%0d_other_gnt", idx), v.who ? m0_gnt : m1_gnt, 0);
        @(posedge clock); #1;
        set_req(v.who, 1'b0, ~v.we, ~v.addr, ~v.wdata);
        @(negedge clock);                                  // cycle 1: access
        check($sformatf("v%0d_write_sg", idx), mem_write_sg, v.we & ~v.exp_err);
        check($sformatf("v%0d_mem_address", idx), mem_address, v.addr);
        check($sformatf("v%0d_gnt_access", idx), {m0_gnt, m1_gnt}, 0);
        @(posedge clock); #1;
        @(negedge clock);                                  // cycle 2: completion
        check($sformatf("v%0d_rvalid", idx), v.who ? m1_rvalid : m0_rvalid, 1);
        check($sformatf("v%0d_other_rvalid", idx), v.who ? m0_rvalid : m1_rvalid, 0);
        check($sformatf("v%0d_rdata", idx), v.who ? m1_rdata : m0_rdata, v.exp_rdata);
        check($sformatf("v%0d_err", idx), v.who ? m1_err : m0_err, v.exp_err);
        check($sformatf("v%0d_other_rdata_hold", idx), o ? m1_rdata : m0_rdata, last_rdata[o]);
        check($sformatf("v%0d_write_sg_idle", idx), mem_write_sg, 0);
        check($sformatf("v%0d_mem_address_hold", idx), mem_address, v.addr);
        last_rdata[v.who] = v.exp_rdata;
    endtask

    initial begin
        logic exp_rv0;
        logic exp_rv1;
        n_vec = 0;
        n_mis = 0;
        last_rdata[0] = 32'h0;
        last_rdata[1] = 32'h0;

        //            who   we    addr           wdata          exp_rdata      exp_err
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0,         1'b1};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_0000, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0011, 32'h0,         1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0011, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0105, 32'h0,         32'h0,         1'b1};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_00FF, 32'hCAFE_F00D, 32'h0,         1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_00FF, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h8000_0010, 32'h0,         32'h0,         1'b1};

        reset_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        @(negedge clock);
        check("reset_gnt", {m0_gnt, m1_gnt}, 0);
        check("reset_rvalid", {m0_rvalid, m1_rvalid}, 0);
        check("reset_err", {m0_err, m1_err}, 0);
        check("reset_m0_rdata", m0_rdata, 0);
        check("reset_m1_rdata", m1_rdata, 0);
        check("reset_write_sg", mem_write_sg, 0);
        check("reset_mem_address", mem_address, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);
        check("oob_write_kept_word0", mem[0], 32'hA5A5_0000);

        // Write then immediate read of the same word with req held high;
        // attributes changed after the grant must not disturb the write.
        @(posedge clock); #1;
        set_req(1'b0, 1'b1, 1'b1, 32'h20, 32'h5);
        @(negedge clock);
        check("wr_rd_gnt0", m0_gnt, 1);
        @(posedge clock); #1;
        m0_we = 1'b0; m0_wdata = 32'hFFFF_FFFF;
        @(negedge clock);
        check("wr_rd_write_sg", mem_write_sg, 1);
        check("wr_rd_write_data", mem_write_data, 32'h5);
        check("wr_rd_gnt_access", m0_gnt, 0);
        @(posedge clock); #1;
        @(negedge clock);
        check("wr_rd_ack_rvalid", m0_rvalid, 1);
        check("wr_rd_ack_rdata", m0_rdata, 0);
        check("wr_rd_regrant", m0_gnt, 1);
        @(posedge clock); #1;
        m0_req = 1'b0;
        @(negedge clock);
        check("wr_rd_gap_rvalid", m0_rvalid, 0);
        check("wr_rd_read_write_sg", mem_write_sg, 0);
        @(posedge clock); #1;
        @(negedge clock);
        check("wr_rd_read_rvalid", m0_rvalid, 1);
        check("wr_rd_read_rdata", m0_rdata, 32'h5);
        check("wr_rd_read_err", m0_err, 0);

        // Reset asserted mid-ACCESS of a write to 0x30 aborts it.
        @(posedge clock); #1;
        set_req(1'b0, 1'b1, 1'b1, 32'h30, 32'hBAD0_BAD0);
        @(negedge clock);
        check("abort_gnt0", m0_gnt, 1);
        @(posedge clock); #1;
        m0_req = 1'b0;
        @(negedge clock);
        check("abort_write_sg_before", mem_write_sg, 1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_write_sg_dropped", mem_write_sg, 0);
        @(posedge clock); #1;
        check("abort_mem30_kept", mem[8'h30], 32'hA5A5_0030);
        @(negedge clock);
        check("abort_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
        reset_n = 1'b1;

        // Both requesting continuously after reset: m0 first, then strict alternation.
        @(posedge clock); #1;
        set_req(1'b0, 1'b1, 1'b0, 32'h24, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check($sformatf("alt_k%0d_gnt0", k), m0_gnt, (k % 4) == 0);
            check($sformatf("alt_k%0d_gnt1", k), m1_gnt, (k % 4) == 2);
            exp_rv0 = (k == 2) || (k == 6);
            exp_rv1 = (k == 4);
            check($sformatf("alt_k%0d_rvalid0", k), m0_rvalid, exp_rv0);
            check($sformatf("alt_k%0d_rvalid1", k), m1_rvalid, exp_rv1);
            if (exp_rv0) check($sformatf("alt_k%0d_rdata0", k), m0_rdata, 32'hA5A5_0024);
            if (exp_rv1) check($sformatf("alt_k%0d_rdata1", k), m1_rdata, 32'hDEAD_BEEF);
            @(posedge clock); #1;
        end
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        check("alt_last_rvalid1", m1_rvalid, 1);
        check("alt_last_rdata1", m1_rdata, 32'hDEAD_BEEF);
        check("alt_last_gnt", {m0_gnt, m1_gnt}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
